// File: rtl/pcla_pkg.sv
// Shared definitions for the pipelined carry-look-ahead add/subtract unit.
// Provides the default segment width, the depth helper and the per-stage token control record.
package pcla_pkg;

    localparam int PCLA_SEG_W = 4;

    // Pipeline depth: one stage per SEG_W-bit segment.
    function automatic int pcla_nseg(input int width, input int seg_w);
        return width / seg_w;
    endfunction

    // Control part of a token; the operand and sum slices travel beside it
    // with widths that shrink (operands) or grow (sum) stage by stage.
    typedef struct packed {
        logic valid;
        logic carry;
    } pcla_tok_t;

endpackage

// File: rtl/cla_segment.sv
// Combinational SEG_W-bit carry-look-ahead segment.
// Ports: a, b, ci in; s (segment sum), co (group carry out), cm (carry into MSB, PCLA_OVERFLOW_EN only).
module cla_segment #(
    parameter int SEG_W = 4
) (
    input  logic [SEG_W-1:0] a,
    input  logic [SEG_W-1:0] b,
    input  logic             ci,
    output logic [SEG_W-1:0] s,
    output logic             co
`ifdef PCLA_OVERFLOW_EN
    ,
    output logic             cm
`endif
);

    logic [SEG_W-1:0] g;
    logic [SEG_W-1:0] p;
    logic [SEG_W:0]   c;

    assign g = a & b;
    assign p = a ^ b;

    // Every carry is expanded in sum-of-products form from g/p and ci,
    // so no carry depends on a lower computed carry.
    always_comb begin
        logic run;
        run  = 1'b0;
        c    = '0;
        c[0] = ci;
        for (int i = 0; i < SEG_W; i++) begin
            c[i+1] = g[i];
            run    = p[i];
            for (int j = i - 1; j >= 0; j--) begin
                c[i+1] = c[i+1] | (run & g[j]);
                run    = run & p[j];
            end
            c[i+1] = c[i+1] | (run & ci);
        end
    end

    assign s  = p ^ c[SEG_W-1:0];
    assign co = c[SEG_W];
`ifdef PCLA_OVERFLOW_EN
    assign cm = c[SEG_W-1];
`endif

endmodule

// File: rtl/pipelined_cla_adder.sv
// Pipelined CLA add/subtract: one SEG_W-bit segment per stage, carry passed stage to stage.
// Ports: clk, rst_n (sync, active low), in_valid/in_ready + a, b, cin, sub in;
//        out_valid/out_ready + sum, cout out; ovf out only when PCLA_OVERFLOW_EN is defined.
module pipelined_cla_adder
    import pcla_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SEG_W = PCLA_SEG_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef PCLA_OVERFLOW_EN
    ,
    output logic             ovf
`endif
);

    localparam int NSEG = pcla_nseg(WIDTH, SEG_W);
    localparam int LAST = NSEG - 1;

    logic             stall;
    logic [WIDTH-1:0] b_eff;
    logic             cin_eff;

    // Subtraction as a + ~b + ~cin: the borrow-in becomes an inverted carry-in.
    assign b_eff   = sub ? ~b : b;
    assign cin_eff = sub ^ cin;

    for (genvar k = 0; k < NSEG; k++) begin : g_stage
        localparam int LO = k * SEG_W;
        localparam int RW = WIDTH - LO;

        logic [RW-1:0]       a_i;
        logic [RW-1:0]       b_i;
        logic                c_i;
        logic                v_i;
        logic [SEG_W-1:0]    seg_s;
        logic                seg_c;
        logic [LO+SEG_W-1:0] s_d;
        logic [LO+SEG_W-1:0] s_q;
        pcla_tok_t           tok_q;
`ifdef PCLA_OVERFLOW_EN
        logic                seg_m;
`endif

        if (k == 0) begin : g_in
            assign a_i = a;
            assign b_i = b_eff;
            assign c_i = cin_eff;
            assign v_i = in_valid;
            assign s_d = seg_s;
        end else begin : g_link
            assign a_i = g_stage[k-1].g_fwd.a_q;
            assign b_i = g_stage[k-1].g_fwd.b_q;
            assign c_i = g_stage[k-1].tok_q.carry;
            assign v_i = g_stage[k-1].tok_q.valid;
            assign s_d = {seg_s, g_stage[k-1].s_q};
        end

        cla_segment #(
            .SEG_W(SEG_W)
        ) u_seg (
            .a  (a_i[SEG_W-1:0]),
            .b  (b_i[SEG_W-1:0]),
            .ci (c_i),
            .s  (seg_s),
            .co (seg_c)
`ifdef PCLA_OVERFLOW_EN
            ,
            .cm (seg_m)
`endif
        );

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                s_q   <= '0;
                tok_q <= '0;
            end else if (!stall) begin
                s_q         <= s_d;
                tok_q.valid <= v_i;
                tok_q.carry <= seg_c;
            end
        end

        // Unresolved upper operand bits; the final stage has none left.
        if (k < LAST) begin : g_fwd
            logic [RW-SEG_W-1:0] a_q;
            logic [RW-SEG_W-1:0] b_q;

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (!stall) begin
                    a_q <= a_i[RW-1:SEG_W];
                    b_q <= b_i[RW-1:SEG_W];
                end
            end
        end

`ifdef PCLA_OVERFLOW_EN
        if (k == LAST) begin : g_ovf
            logic ovf_q;

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    ovf_q <= 1'b0;
                end else if (!stall) begin
                    ovf_q <= seg_m ^ seg_c;
                end
            end
        end
`endif
    end

    assign out_valid = g_stage[LAST].tok_q.valid;
    assign sum       = g_stage[LAST].s_q;
    assign cout      = g_stage[LAST].tok_q.carry;
`ifdef PCLA_OVERFLOW_EN
    assign ovf       = g_stage[LAST].g_ovf.ovf_q;
`endif

    // A held result freezes every stage, bubbles included.
    assign stall    = out_valid && !out_ready;
    assign in_ready = !stall;

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Self-checking bench for pipelined_cla_adder at WIDTH=8, SEG_W=4 (two stages).
// Directed cases plus randomized traffic checked against an arithmetic reference queue.
module tb_pipelined_cla_adder;

    localparam int W = 8;

    typedef struct {
        logic [W-1:0] s;
        logic         c;
        logic         o;
    } exp_t;

    logic         clk       = 1'b0;
    logic         rst_n     = 1'b0;
    logic         in_valid  = 1'b0;
    logic         out_ready = 1'b1;
    logic         cin       = 1'b0;
    logic         sub       = 1'b0;
    logic [W-1:0] a         = '0;
    logic [W-1:0] b         = '0;
    logic         in_ready;
    logic         out_valid;
    logic [W-1:0] sum;
    logic         cout;
`ifdef PCLA_OVERFLOW_EN
    logic         ovf;
`endif

    exp_t q[$];
    exp_t nxt;
    int   checks   = 0;
    int   failures = 0;
    int   run_len  = 0;
    int   max_run  = 0;

    pipelined_cla_adder #(
        .WIDTH(W),
        .SEG_W(4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout)
`ifdef PCLA_OVERFLOW_EN
        ,
        .ovf       (ovf)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic exp_t mk(int s, int c, int o);
        exp_t e;
        e.s = W'(s);
        e.c = (c != 0);
        e.o = (o != 0);
        return e;
    endfunction

    // Reference: plain integer arithmetic on the operation's meaning.
    function automatic exp_t model(logic [W-1:0] x, logic [W-1:0] y, logic ci, logic sb);
        exp_t e;
        int   r;
        int   sx;
        int   sy;
        int   sr;
        sx = (x >= 128) ? int'(x) - 256 : int'(x);
        sy = (y >= 128) ? int'(y) - 256 : int'(y);
        if (sb) begin
            r  = 256 + int'(x) - int'(y) - int'(ci);
            sr = sx - sy - int'(ci);
        end else begin
            r  = int'(x) + int'(y) + int'(ci);
            sr = sx + sy + int'(ci);
        end
        e.s = W'(r % 256);
        e.c = (r >= 256);
        e.o = (sr > 127) || (sr < -128);
        return e;
    endfunction

    // One cycle: inputs were set at the preceding negedge.
    task automatic tick();
        exp_t e;
        #1;
        if (rst_n && in_valid && in_ready === 1'b1)
            q.push_back(nxt);
        if (rst_n && out_ready && out_valid === 1'b1) begin
            if (q.size() == 0) begin
                check("spurious_out", 1, 0);
            end else begin
                e = q.pop_front();
                check("sum", sum, e.s);
                check("cout", cout, e.c);
`ifdef PCLA_OVERFLOW_EN
                check("ovf", ovf, e.o);
`endif
            end
        end
        if (out_valid === 1'b1) begin
            run_len++;
            if (run_len > max_run) max_run = run_len;
        end else begin
            run_len = 0;
        end
        @(posedge clk);
        if (!rst_n) q.delete();
        @(negedge clk);
    endtask

    task automatic send(logic [W-1:0] x, logic [W-1:0] y, logic ci, logic sb, exp_t e);
        in_valid = 1'b1;
        a        = x;
        b        = y;
        cin      = ci;
        sub      = sb;
        nxt      = e;
        tick();
    endtask

    task automatic send_rand();
        logic [W-1:0] x;
        logic [W-1:0] y;
        logic         ci;
        logic         sb;
        x  = W'($urandom);
        y  = W'($urandom);
        ci = 1'($urandom);
        sb = 1'($urandom);
        send(x, y, ci, sb, model(x, y, ci, sb));
    endtask

    task automatic drain();
        int n;
        n         = 0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        while (q.size() != 0 && n < 20) begin
            tick();
            n++;
        end
        check("drain_empty", q.size(), 0);
    endtask

    initial begin
        logic [W-1:0] s0;
        logic         c0;
        int           n;

        @(negedge clk);
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        check("rst_out_valid", out_valid, 0);
        check("rst_sum", sum, 0);
        check("rst_cout", cout, 0);
        check("rst_in_ready", in_ready, 1);
`ifdef PCLA_OVERFLOW_EN
        check("rst_ovf", ovf, 0);
`endif

        // Latency: result visible two cycles after the operand cycle.
        send(8'd150, 8'd32, 1'b1, 1'b0, mk(183, 0, 0));
        in_valid = 1'b0;
        check("lat_early", out_valid, 0);
        tick();
        check("lat_valid", out_valid, 1);
        check("lat_sum", sum, 183);
        drain();

        // Back-to-back: carry-out, overflow, wrap, subtraction both ways.
        max_run = 0;
        send(8'd200, 8'd100, 1'b0, 1'b0, mk(44, 1, 0));
        check("b2b_ready0", in_ready, 1);
        send(8'd100, 8'd100, 1'b0, 1'b0, mk(200, 0, 1));
        check("b2b_ready1", in_ready, 1);
        send(8'd255, 8'd1, 1'b0, 1'b0, mk(0, 1, 0));
        check("b2b_ready2", in_ready, 1);
        send(8'd5, 8'd7, 1'b0, 1'b1, mk(254, 0, 0));
        check("b2b_ready3", in_ready, 1);
        send(8'd7, 8'd5, 1'b0, 1'b1, mk(2, 1, 0));
        drain();
        check("b2b_run", max_run, 5);

        // Stall: hold the consumer off, offer operands that must be ignored.
        send_rand();
        send_rand();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        n = 0;
        while (out_valid !== 1'b1 && n < 10) begin
            tick();
            n++;
        end
        check("stall_valid", out_valid, 1);
        s0 = sum;
        c0 = cout;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            a        = W'($urandom);
            b        = W'($urandom);
            nxt      = model(a, b, cin, sub);
            tick();
            check("stall_in_ready", in_ready, 0);
            check("stall_sum", sum, s0);
            check("stall_cout", cout, c0);
        end
        check("stall_pending", q.size(), 2);
        drain();

        // Reset with two tokens in flight.
        send_rand();
        send_rand();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        rst_n     = 1'b0;
        tick();
        rst_n     = 1'b1;
        out_ready = 1'b1;
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_sum", sum, 0);
        check("mid_rst_cout", cout, 0);
        check("mid_rst_ready", in_ready, 1);
        tick();
        check("post_rst_valid0", out_valid, 0);
        tick();
        check("post_rst_valid1", out_valid, 0);
        send(8'd3, 8'd4, 1'b0, 1'b0, mk(7, 0, 0));
        drain();

        // Random traffic with random back-pressure.
        for (int i = 0; i < 400; i++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 3) != 0) begin
                send_rand();
            end else begin
                in_valid = 1'b0;
                tick();
            end
        end
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
